// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the register-file write port between
// the WB stage and a one-entry buffer holding the mul/div result.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic [DATA_W-1:0] buf_data,
  output logic              wb_sel,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic              stall_req,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_W-1:0]  buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              stall_q, stall_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              pipe_nz;

  assign md_ready  = (state_q == IDLE) & ~rst;
  assign xfer      = md_valid & md_ready;
  assign pipe_nz   = (pipe_rd != '0);
  assign buf_data  = buf_data_q;
  assign stall_req = stall_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && (md_rd != '0)) begin
          buf_rd_d   = md_rd;
          buf_data_d = md_data;
          cnt_d      = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // a younger pipeline write to the same rd kills the buffer
        if (!pipe_we || (pipe_rd == buf_rd_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FORCE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FORCE: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (pipe_we) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d == FORCE);
  end

  always_comb begin
    wb_sel   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          rf_we    = pipe_we & pipe_nz;
          rf_waddr = pipe_rd;
        end
        HOLD: begin
          if (pipe_we) begin
            rf_we    = pipe_nz;
            rf_waddr = pipe_rd;
          end else begin
            wb_sel   = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = buf_rd_q;
          end
        end
        FORCE: begin
          wb_sel   = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = buf_rd_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed cycles push expected
// outputs, a negedge monitor pops and compares them.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic [31:0] buf_data;
  logic        wb_sel;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        stall_req;
  logic        err;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic [41:0] v;
  } exp_t;

  exp_t sb[$];

  wb_port_arbiter #(
    .DATA_W(32), .REG_W(5), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .md_ready(md_ready), .buf_data(buf_data),
    .wb_sel(wb_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .stall_req(stall_req), .err(err)
  );

  always #5 clk = ~clk;

  // inputs change 2 time units after the rising edge
  task automatic cyc(
    input logic r, input logic pwe, input logic [4:0] prd,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
    input logic e_rdy, input logic e_sel, input logic e_we,
    input logic [4:0] e_wa, input logic e_st, input logic e_err,
    input logic [31:0] e_buf, input string name);
    exp_t e;
    @(posedge clk);
    #2;
    rst      = r;
    pipe_we  = pwe;
    pipe_rd  = prd;
    md_valid = mv;
    md_rd    = mrd;
    md_data  = mdat;
    e.name = name;
    e.v    = {e_rdy, e_sel, e_we, e_wa, e_st, e_err, e_buf};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [41:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {md_ready, wb_sel, rf_we, rf_waddr, stall_req, err, buf_data};
      checks++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got rdy/sel/we/wa/st/err/buf=%h required %h",
                 e.name, act, e.v);
      end
    end
  end

  initial begin
    // r pwe prd mv mrd data | rdy sel we wa st err buf
    cyc(1,0,0, 0,0,0,            0,0,0,0,0,0,32'h0,        "reset");
    cyc(0,0,0, 1,5,32'hDEADBEEF, 1,0,0,0,0,0,32'h0,        "accept5");
    cyc(0,0,0, 0,0,0,            0,1,1,5,0,0,32'hDEADBEEF, "drain5");
    cyc(0,0,0, 0,0,0,            1,0,0,0,0,0,32'hDEADBEEF, "ready_after");
    cyc(0,0,0, 1,0,32'h1234,     1,0,0,0,0,0,32'hDEADBEEF, "x0_md");
    cyc(0,1,0, 0,0,0,            1,0,0,0,0,0,32'hDEADBEEF, "x0_pipe");
    cyc(0,1,12,0,0,0,            1,0,1,12,0,0,32'hDEADBEEF,"idle_pipe");
    cyc(0,0,0, 1,7,32'hA5A5A5A5, 1,0,0,0,0,0,32'hDEADBEEF, "accept7");
    for (int i = 0; i < 4; i++)
      cyc(0,1,3, 0,0,0,          0,0,1,3,0,0,32'hA5A5A5A5, "blocked");
    cyc(0,0,0, 0,0,0,            0,1,1,7,1,0,32'hA5A5A5A5, "force7");
    cyc(0,0,0, 0,0,0,            1,0,0,0,0,0,32'hA5A5A5A5, "after_force");
    cyc(0,0,0, 1,9,32'h11111111, 1,0,0,0,0,0,32'hA5A5A5A5, "accept9");
    cyc(0,1,9, 0,0,0,            0,0,1,9,0,0,32'h11111111, "waw_pipe");
    cyc(0,0,0, 0,0,0,            1,0,0,0,0,0,32'h11111111, "waw_killed");
    cyc(0,0,0, 1,4,32'hCAFEF00D, 1,0,0,0,0,0,32'h11111111, "accept4");
    for (int i = 0; i < 4; i++)
      cyc(0,1,2, 0,0,0,          0,0,1,2,0,0,32'hCAFEF00D, "blocked2");
    cyc(0,1,2, 0,0,0,            0,1,1,4,1,0,32'hCAFEF00D, "force_viol");
    cyc(0,0,0, 0,0,0,            1,0,0,0,0,1,32'hCAFEF00D, "err_set");
    cyc(0,1,6, 0,0,0,            1,0,1,6,0,1,32'hCAFEF00D, "err_sticky");
    cyc(0,0,0, 1,8,32'h0BADCAFE, 1,0,0,0,0,1,32'hCAFEF00D, "accept8");
    cyc(0,1,1, 0,0,0,            0,0,1,1,0,1,32'h0BADCAFE, "hold8");
    cyc(1,1,1, 0,0,0,            0,0,0,0,0,0,32'h0,        "async_rst");
    cyc(0,0,0, 0,0,0,            1,0,0,0,0,0,32'h0,        "post_rst");
    cyc(0,0,0, 0,0,0,            1,0,0,0,0,0,32'h0,        "no_old_write");
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_sb: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
